instruction_encoder: RTL and testbench

Sequential encoder that turns field-level instruction requests (the same 11-bit operation codes and register/immediate fields the CPU's instruction decoder emits) into 32-bit ARM words. It writes them sequentially into instruction memory through a write handshake. It sits between the test/program-loader logic and the instruction RAM, and computes PC-relative branch offsets from its own write pointer.

---
 rtl/instr_enc_pkg.sv | 55 +++++
 rtl/instr_field_pack.sv | 74 +++++++
 rtl/instruction_encoder.sv | 112 +++++++++++
 tb/tb_instruction_encoder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_enc_pkg.sv
// Shared operation codes, data-processing opcodes, FSM state and request record
// for the instruction encoder.
package instr_enc_pkg;

    // Operation codes use the decoder's numbering so both ends agree.
    localparam logic [10:0] CODE_ADD  = 11'd0;
    localparam logic [10:0] CODE_SUB  = 11'd2;
    localparam logic [10:0] CODE_AND  = 11'd3;
    localparam logic [10:0] CODE_ORR  = 11'd4;
    localparam logic [10:0] CODE_EOR  = 11'd5;
    localparam logic [10:0] CODE_MOV  = 11'd6;
    localparam logic [10:0] CODE_MVN  = 11'd7;
    localparam logic [10:0] CODE_CMP  = 11'd8;
    localparam logic [10:0] CODE_TST  = 11'd9;
    localparam logic [10:0] CODE_TEQ  = 11'd10;
    localparam logic [10:0] CODE_BIC  = 11'd11;
    localparam logic [10:0] CODE_CMPI = 11'd13;
    localparam logic [10:0] CODE_B    = 11'd31;
    localparam logic [10:0] CODE_BL   = 11'd32;
    localparam logic [10:0] CODE_LDR  = 11'd41;
    localparam logic [10:0] CODE_STR  = 11'd42;

    localparam logic [3:0] DP_AND = 4'b0000;
    localparam logic [3:0] DP_EOR = 4'b0001;
    localparam logic [3:0] DP_SUB = 4'b0010;
    localparam logic [3:0] DP_ADD = 4'b0100;
    localparam logic [3:0] DP_TST = 4'b1000;
    localparam logic [3:0] DP_TEQ = 4'b1001;
    localparam logic [3:0] DP_CMP = 4'b1010;
    localparam logic [3:0] DP_ORR = 4'b1100;
    localparam logic [3:0] DP_MOV = 4'b1101;
    localparam logic [3:0] DP_BIC = 4'b1110;
    localparam logic [3:0] DP_MVN = 4'b1111;

    typedef enum logic {
        ST_IDLE,
        ST_WRITE
    } state_t;

    typedef struct packed {
        logic [10:0] code;
        logic [3:0]  cond;
        logic        s;
        logic        imm;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [7:0]  shift;
        logic [3:0]  rotate;
        logic [7:0]  imm8;
        logic [11:0] offset12;
        logic [31:0] target;
    } enc_req_t;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational formatter: request fields plus current write pointer -> ARM word.
// Branch range/alignment checking is enabled by INSTR_ENC_RANGE_CHECK_EN.
module instr_field_pack
    import instr_enc_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  enc_req_t          req,
    input  logic [ADDR_W-1:0] ptr,
    output logic [31:0]       word,
    output logic              code_ok,
    output logic              range_ok
);

    logic [3:0]  dp_op;
    logic        is_dp, is_br, is_mem, link, load, rn_zero, is_cmp, imm_f;
    logic [11:0] op2;
    logic [31:0] diff, dp_word, br_word, mem_word;
    logic        br_ok;

    always_comb begin
        dp_op   = '0;
        is_dp   = 1'b0;
        is_br   = 1'b0;
        is_mem  = 1'b0;
        link    = 1'b0;
        load    = 1'b0;
        rn_zero = 1'b0;
        is_cmp  = 1'b0;
        imm_f   = req.imm;
        case (req.code)
            CODE_ADD:  begin is_dp = 1'b1; dp_op = DP_ADD; end
            CODE_SUB:  begin is_dp = 1'b1; dp_op = DP_SUB; end
            CODE_AND:  begin is_dp = 1'b1; dp_op = DP_AND; end
            CODE_ORR:  begin is_dp = 1'b1; dp_op = DP_ORR; end
            CODE_EOR:  begin is_dp = 1'b1; dp_op = DP_EOR; end
            CODE_BIC:  begin is_dp = 1'b1; dp_op = DP_BIC; end
            CODE_MOV:  begin is_dp = 1'b1; dp_op = DP_MOV; rn_zero = 1'b1; end
            CODE_MVN:  begin is_dp = 1'b1; dp_op = DP_MVN; rn_zero = 1'b1; end
            CODE_CMP:  begin is_dp = 1'b1; dp_op = DP_CMP; is_cmp = 1'b1; end
            CODE_TST:  begin is_dp = 1'b1; dp_op = DP_TST; is_cmp = 1'b1; end
            CODE_TEQ:  begin is_dp = 1'b1; dp_op = DP_TEQ; is_cmp = 1'b1; end
            CODE_CMPI: begin is_dp = 1'b1; dp_op = DP_CMP; is_cmp = 1'b1; imm_f = 1'b1; end
            CODE_B:    is_br = 1'b1;
            CODE_BL:   begin is_br = 1'b1; link = 1'b1; end
            CODE_LDR:  begin is_mem = 1'b1; load = 1'b1; end
            CODE_STR:  is_mem = 1'b1;
            default:   ;
        endcase
    end

    // PC reads two words ahead of the instruction being written.
    assign diff = req.target - ((32'(ptr) << 2) + 32'd8);

    assign op2      = imm_f ? {req.rotate, req.imm8} : {req.shift, req.rm};
    assign dp_word  = {req.cond, 2'b00, imm_f, dp_op, req.s | is_cmp,
                       rn_zero ? 4'd0 : req.rn, is_cmp ? 4'd0 : req.rd, op2};
    assign br_word  = {req.cond, 3'b101, link, diff[25:2]};
    assign mem_word = {req.cond, 2'b01, 1'b0, 1'b1, 1'b1, 2'b00, load,
                       req.rn, req.rd, req.offset12};

`ifdef INSTR_ENC_RANGE_CHECK_EN
    assign br_ok = (diff[1:0] == 2'b00) && (diff[31:25] == {7{diff[25]}});
`else
    logic unused_diff_bits;
    assign unused_diff_bits = ^{diff[31:26], diff[1:0]};
    assign br_ok = 1'b1;
`endif

    assign word     = is_dp ? dp_word : is_br ? br_word : is_mem ? mem_word : 32'd0;
    assign code_ok  = is_dp | is_br | is_mem;
    assign range_ok = ~is_br | br_ok;

endmodule

// File: rtl/instruction_encoder.sv
// Sequential instruction encoder: accepts field-level requests and writes ARM
// words to instruction memory. INSTR_ENC_RANGE_CHECK_EN enables branch checks.
module instruction_encoder
    import instr_enc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [10:0]       in_code,
    input  logic [3:0]        in_cond,
    input  logic              in_s,
    input  logic              in_imm,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rm,
    input  logic [7:0]        in_shift,
    input  logic [3:0]        in_rotate,
    input  logic [7:0]        in_imm8,
    input  logic [11:0]       in_offset12,
    input  logic [31:0]       in_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              busy,
    output logic              err_code,
    output logic              err_range
);

    state_t      state;
    enc_req_t    req;
    logic [31:0] word;
    logic        code_ok, range_ok;

    assign req = '{code: in_code, cond: in_cond, s: in_s, imm: in_imm,
                   rd: in_rd, rn: in_rn, rm: in_rm, shift: in_shift,
                   rotate: in_rotate, imm8: in_imm8, offset12: in_offset12,
                   target: in_target};

    instr_field_pack #(.ADDR_W(ADDR_W)) u_pack (
        .req      (req),
        .ptr      (wr_ptr),
        .word     (word),
        .code_ok  (code_ok),
        .range_ok (range_ok)
    );

    assign in_ready = (state == ST_IDLE) && !full;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wr_ptr    <= BASE_ADDR;
            count     <= '0;
            full      <= 1'b0;
            err_code  <= 1'b0;
            err_range <= 1'b0;
        end else if (start) begin
            // Restart drops any pending write, even one being acked now.
            state     <= ST_IDLE;
            mem_we    <= 1'b0;
            wr_ptr    <= BASE_ADDR;
            count     <= '0;
            full      <= 1'b0;
            err_code  <= 1'b0;
            err_range <= 1'b0;
        end else begin
            err_code  <= 1'b0;
            err_range <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        if (!code_ok) begin
                            err_code <= 1'b1;
                        end else if (!range_ok) begin
                            err_range <= 1'b1;
                        end else begin
                            mem_addr  <= wr_ptr;
                            mem_wdata <= word;
                            mem_we    <= 1'b1;
                            state     <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_ack) begin
                        mem_we <= 1'b0;
                        state  <= ST_IDLE;
                        count  <= count + 1'b1;
                        // No wrap: the pointer parks on the last address.
                        if (wr_ptr == {ADDR_W{1'b1}}) full   <= 1'b1;
                        else                          wr_ptr <= wr_ptr + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: directed vectors plus randomized
// requests checked against an arithmetic encoding model.
module tb_instruction_encoder;
    import instr_enc_pkg::*;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset_n, start, in_valid, in_ready;
    logic [10:0]   in_code;
    logic [3:0]    in_cond, in_rd, in_rn, in_rm, in_rotate;
    logic          in_s, in_imm;
    logic [7:0]    in_shift, in_imm8;
    logic [11:0]   in_offset12;
    logic [31:0]   in_target;
    logic          mem_we, mem_ack, full, busy, err_code, err_range;
    logic [AW-1:0] mem_addr, wr_ptr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instruction_encoder #(.ADDR_W(AW), .BASE_ADDR('0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_code(in_code), .in_cond(in_cond), .in_s(in_s),
        .in_imm(in_imm), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
        .in_shift(in_shift), .in_rotate(in_rotate), .in_imm8(in_imm8),
        .in_offset12(in_offset12), .in_target(in_target), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .wr_ptr(wr_ptr), .count(count), .full(full), .busy(busy),
        .err_code(err_code), .err_range(err_range)
    );

    // Reference encoder: builds the word with plain arithmetic from the field rules.
    // kind: 0 encodable, 1 bad code, 2 branch out of range.
    function automatic void model(input enc_req_t r, input int unsigned ptr,
                                  output logic [31:0] w, output int kind);
        int opc, d;
        logic i, s, cmp;
        logic [3:0] rn, rd;
        kind = 0; w = 0; opc = -1;
        case (int'(r.code))
            0: opc = 4;   2: opc = 2;   3: opc = 0;   4: opc = 12;
            5: opc = 1;   6: opc = 13;  7: opc = 15;  8: opc = 10;
            9: opc = 8;   10: opc = 9;  11: opc = 14; 13: opc = 10;
            default: opc = -1;
        endcase
        if (opc >= 0) begin
            cmp = (r.code == 8 || r.code == 9 || r.code == 10 || r.code == 13);
            i   = (r.code == 13) ? 1'b1 : r.imm;
            s   = cmp ? 1'b1 : r.s;
            rd  = cmp ? 4'd0 : r.rd;
            rn  = (r.code == 6 || r.code == 7) ? 4'd0 : r.rn;
            w   = (32'(r.cond) << 28) | (32'(i) << 25) | (32'(opc) << 21) | (32'(s) << 20)
                | (32'(rn) << 16) | (32'(rd) << 12)
                | (i ? (32'(r.rotate) * 256 + 32'(r.imm8)) : (32'(r.shift) * 16 + 32'(r.rm)));
        end else if (r.code == 31 || r.code == 32) begin
            d = int'(r.target - (ptr * 4 + 8));
`ifdef INSTR_ENC_RANGE_CHECK_EN
            if (d % 4 != 0 || d < -(1 << 25) || d >= (1 << 25)) kind = 2;
`endif
            w = (32'(r.cond) << 28) | (32'd5 << 25) | (32'(r.code == 32) << 24)
              | (32'(d >>> 2) & 32'h00FF_FFFF);
        end else if (r.code == 41 || r.code == 42) begin
            w = (32'(r.cond) << 28) | (32'd1 << 26) | (32'd1 << 24) | (32'd1 << 23)
              | (32'(r.code == 41) << 20) | (32'(r.rn) << 16) | (32'(r.rd) << 12)
              | 32'(r.offset12);
        end else begin
            kind = 1;
        end
    endfunction

    function automatic enc_req_t mk(input int code, input int rd, input int rn, input int rm,
                                    input logic imm, input int imm8, input int off, input int tgt);
        enc_req_t r;
        r = '0;
        r.code = 11'(code); r.cond = 4'hE; r.rd = 4'(rd); r.rn = 4'(rn); r.rm = 4'(rm);
        r.imm = imm; r.imm8 = 8'(imm8); r.offset12 = 12'(off); r.target = 32'(tgt);
        return r;
    endfunction

    // Drives one request starting just after a rising edge; returns what was seen.
    task automatic do_req(input enc_req_t r, input int dly, output logic we,
                          output logic [AW-1:0] a, output logic [31:0] d,
                          output logic ec, output logic er, output logic stable);
        in_code = r.code; in_cond = r.cond; in_s = r.s; in_imm = r.imm;
        in_rd = r.rd; in_rn = r.rn; in_rm = r.rm; in_shift = r.shift;
        in_rotate = r.rotate; in_imm8 = r.imm8; in_offset12 = r.offset12;
        in_target = r.target; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        we = mem_we; a = mem_addr; d = mem_wdata; ec = err_code; er = err_range; stable = 1'b1;
        if (we) begin
            repeat (dly) begin
                @(negedge clk);
                if (mem_we !== 1'b1 || mem_addr !== a || mem_wdata !== d) stable = 1'b0;
            end
            mem_ack = 1'b1;
            @(posedge clk); #1 mem_ack = 1'b0;
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({mem_we, mem_addr, mem_wdata, wr_ptr, count, full, busy, err_code, err_range, in_ready}
            !== {1'b0, 10'd0, 32'd0, 10'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset: we=%b addr=%h wdata=%h ptr=%h cnt=%h full=%b busy=%b ec=%b er=%b rdy=%b (want all 0, rdy=1)",
                     mem_we, mem_addr, mem_wdata, wr_ptr, count, full, busy, err_code, err_range, in_ready);
        end
        @(posedge clk); #1 reset_n = 1'b1;
    endtask

    task automatic test_dp();
        logic we, ec, er, st; logic [AW-1:0] a; logic [31:0] d; enc_req_t r;
        r = mk(0, 5, 7, 6, 0, 0, 0, 0);
        do_req(r, 0, we, a, d, ec, er, st);
        n_cmp++; if ({we, a, d} !== {1'b1, 10'd0, 32'hE0875006}) begin n_bad++;
            $display("FAIL add_reg: we=%b addr=%h data=%h want 1/000/E0875006", we, a, d); end
        n_cmp++; if (count !== 11'd1 || busy !== 1'b0) begin n_bad++;
            $display("FAIL add_count: count=%0d busy=%b want 1/0", count, busy); end
        r = mk(0, 4, 4, 0, 1, 1, 0, 0);
        do_req(r, 0, we, a, d, ec, er, st);
        n_cmp++; if ({we, a, d} !== {1'b1, 10'd1, 32'hE2844001}) begin n_bad++;
            $display("FAIL add_imm: we=%b addr=%h data=%h want 1/001/E2844001", we, a, d); end
        r = mk(6, 0, 9, 3, 0, 0, 0, 0);
        do_req(r, 0, we, a, d, ec, er, st);
        n_cmp++; if ({we, a, d} !== {1'b1, 10'd2, 32'hE1A00003}) begin n_bad++;
            $display("FAIL mov_rn0: we=%b addr=%h data=%h want 1/002/E1A00003", we, a, d); end
    endtask

    task automatic test_branch_mem();
        logic we, ec, er, st; logic [AW-1:0] a; logic [31:0] d;
        do_start();
        do_req(mk(31, 0, 0, 0, 0, 0, 0, 8), 0, we, a, d, ec, er, st);
        n_cmp++; if ({we, a, d} !== {1'b1, 10'd0, 32'hEA000000}) begin n_bad++;
            $display("FAIL b_fwd: we=%b addr=%h data=%h want 1/000/EA000000", we, a, d); end
        do_req(mk(41, 1, 11, 0, 1, 0, 4, 0), 0, we, a, d, ec, er, st);
        n_cmp++; if ({we, a, d} !== {1'b1, 10'd1, 32'hE59B1004}) begin n_bad++;
            $display("FAIL ldr: we=%b addr=%h data=%h want 1/001/E59B1004", we, a, d); end
        do_req(mk(42, 1, 11, 0, 0, 0, 4, 0), 0, we, a, d, ec, er, st);
        n_cmp++; if ({we, a, d} !== {1'b1, 10'd2, 32'hE58B1004}) begin n_bad++;
            $display("FAIL str: we=%b addr=%h data=%h want 1/002/E58B1004", we, a, d); end
        do_req(mk(0, 1, 1, 1, 0, 0, 0, 0), 0, we, a, d, ec, er, st);
        do_req(mk(31, 0, 0, 0, 0, 0, 0, 0), 0, we, a, d, ec, er, st);
        n_cmp++; if ({we, a, d} !== {1'b1, 10'd4, 32'hEAFFFFFA}) begin n_bad++;
            $display("FAIL b_back: we=%b addr=%h data=%h want 1/004/EAFFFFFA", we, a, d); end
    endtask

    task automatic test_errors();
        logic we, ec, er, st; logic [AW-1:0] a; logic [31:0] d;
        do_start();
        do_req(mk(31, 0, 0, 0, 0, 0, 0, 32'h0400_0000), 0, we, a, d, ec, er, st);
`ifdef INSTR_ENC_RANGE_CHECK_EN
        n_cmp++; if ({we, ec, er} !== 3'b001 || wr_ptr !== 10'd0) begin n_bad++;
            $display("FAIL b_range: we=%b ec=%b er=%b ptr=%h want 0/0/1 ptr 000", we, ec, er, wr_ptr); end
`else
        n_cmp++; if ({we, d, er} !== {1'b1, 32'hEAFFFFFE, 1'b0} || wr_ptr !== 10'd1) begin n_bad++;
            $display("FAIL b_trunc: we=%b data=%h er=%b ptr=%h want 1/EAFFFFFE/0 ptr 001", we, d, er, wr_ptr); end
`endif
        n_cmp++; if (err_range !== 1'b0) begin n_bad++;
            $display("FAIL range_pulse_len: err_range=%b want 0", err_range); end
        do_start();
        do_req(mk(20, 1, 2, 3, 0, 0, 0, 0), 0, we, a, d, ec, er, st);
        n_cmp++; if ({we, ec, er} !== 3'b010 || wr_ptr !== 10'd0 || count !== 11'd0) begin n_bad++;
            $display("FAIL bad_code: we=%b ec=%b er=%b ptr=%h cnt=%0d want 0/1/0 ptr 0 cnt 0", we, ec, er, wr_ptr, count); end
        n_cmp++; if (err_code !== 1'b0) begin n_bad++;
            $display("FAIL code_pulse_len: err_code=%b want 0", err_code); end
    endtask

    task automatic test_stall_and_start();
        logic we, ec, er, st; logic [AW-1:0] a; logic [31:0] d;
        do_start();
        do_req(mk(5, 2, 3, 4, 0, 0, 0, 0), 5, we, a, d, ec, er, st);
        n_cmp++; if ({we, st, a} !== {1'b1, 1'b1, 10'd0} || count !== 11'd1) begin n_bad++;
            $display("FAIL stall: we=%b stable=%b addr=%h cnt=%0d want 1/1/000 cnt 1", we, st, a, count); end
        // start collides with the ack of a pending write: write must be dropped
        in_code = 11'd0; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        start = 1'b1; mem_ack = 1'b1;
        @(posedge clk); #1 start = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if ({mem_we, busy, full} !== 3'b000 || wr_ptr !== 10'd0 || count !== 11'd0) begin n_bad++;
            $display("FAIL start_abort: we=%b busy=%b full=%b ptr=%h cnt=%0d want 0/0/0 ptr 0 cnt 0",
                     mem_we, busy, full, wr_ptr, count); end
        @(posedge clk); #1;
        in_code = 11'd0; in_valid = 1'b1; start = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_we !== 1'b0 || busy !== 1'b0) begin n_bad++;
            $display("FAIL start_blocks_valid: we=%b busy=%b want 0/0", mem_we, busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic we, ec, er, st; logic [AW-1:0] a; logic [31:0] d, w;
        int kind, exp_ptr, exp_cnt, bad;
        int codes[20] = '{0, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 13, 31, 32, 41, 42, 1, 12, 20, 2047};
        enc_req_t r;
        do_start();
        exp_ptr = 0; exp_cnt = 0;
        for (int it = 0; it < 80; it++) begin
            r = '{code: 11'(codes[$urandom_range(0, 19)]), cond: 4'($urandom), s: 1'($urandom),
                  imm: 1'($urandom), rd: 4'($urandom), rn: 4'($urandom), rm: 4'($urandom),
                  shift: 8'($urandom), rotate: 4'($urandom), imm8: 8'($urandom),
                  offset12: 12'($urandom), target: $urandom};
            if ($urandom_range(0, 1) == 1)
                r.target = 32'(exp_ptr * 4 + 8 + ($urandom_range(0, 200) - 100) * 4);
            model(r, exp_ptr, w, kind);
            do_req(r, $urandom_range(0, 3), we, a, d, ec, er, st);
            bad = 0;
            if (kind == 0) begin
                exp_ptr++; exp_cnt++;
                if ({we, st, ec, er} !== 4'b1100 || a !== 10'(exp_ptr - 1) || d !== w) bad = 1;
            end else begin
                if (we !== 1'b0 || ec !== (kind == 1) || er !== (kind == 2)) bad = 1;
            end
            n_cmp++;
            if (bad != 0 || wr_ptr !== 10'(exp_ptr) || count !== 11'(exp_cnt)) begin n_bad++;
                $display("FAIL rand[%0d] code=%0d: we=%b addr=%h data=%h ec=%b er=%b ptr=%h cnt=%0d want kind=%0d addr=%h data=%h ptr=%h cnt=%0d",
                         it, r.code, we, a, d, ec, er, wr_ptr, count, kind, 10'(exp_ptr - 1), w, 10'(exp_ptr), exp_cnt); end
        end
    endtask

    task automatic test_fill();
        logic we, ec, er, st; logic [AW-1:0] a; logic [31:0] d;
        int bad;
        do_start();
        bad = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            do_req(mk(6, 1, 0, 2, 0, 0, 0, 0), 0, we, a, d, ec, er, st);
            if (we !== 1'b1 || a !== 10'(i) || d !== 32'hE1A01002) bad++;
            if (i < (1 << AW) - 1 && full !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++;
            $display("FAIL fill_writes: %0d bad writes want 0", bad); end
        n_cmp++; if ({full, in_ready} !== 2'b10 || wr_ptr !== 10'h3FF || count !== 11'd1024) begin n_bad++;
            $display("FAIL full: full=%b rdy=%b ptr=%h cnt=%0d want 1/0 ptr 3FF cnt 1024", full, in_ready, wr_ptr, count); end
        do_req(mk(6, 1, 0, 2, 0, 0, 0, 0), 0, we, a, d, ec, er, st);
        n_cmp++; if (we !== 1'b0 || count !== 11'd1024) begin n_bad++;
            $display("FAIL full_blocks: we=%b cnt=%0d want 0 cnt 1024", we, count); end
        do_start();
        @(negedge clk);
        n_cmp++; if ({full, in_ready} !== 2'b01 || count !== 11'd0) begin n_bad++;
            $display("FAIL full_clear: full=%b rdy=%b cnt=%0d want 0/1 cnt 0", full, in_ready, count); end
    endtask

    initial begin
        in_valid = 1'b0; start = 1'b0; mem_ack = 1'b0; reset_n = 1'b0;
        in_code = '0; in_cond = '0; in_s = 1'b0; in_imm = 1'b0; in_rd = '0; in_rn = '0;
        in_rm = '0; in_shift = '0; in_rotate = '0; in_imm8 = '0; in_offset12 = '0; in_target = '0;
        test_reset();
        test_dp();
        test_branch_mem();
        test_errors();
        test_stall_and_start();
        test_random();
        test_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
